// File: rtl/spi_rc_frame_ctrl.sv
// Receive-side frame controller for spiifc: writes incoming words into a
// circular BRAM buffer, delimits frames with SPI_SS, queues frame descriptors
// and hands them to a consumer with a valid/ack handshake. Frames that do not
// fit in the buffer or the descriptor queue are dropped and counted.
module spi_rc_frame_ctrl #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DESC_DEPTH = 8
) (
    input  logic              SysClk,
    input  logic              Reset_n,
    input  logic              SPI_SS,
    input  logic [15:0]       rcMemData,
    input  logic              rcMemWE,
    output logic [ADDR_W-1:0] bufWrAddr,
    output logic [15:0]       bufWrData,
    output logic              bufWE,
    output logic              frameValid,
    output logic [ADDR_W-1:0] frameStart,
    output logic [ADDR_W:0]   frameLen,
    input  logic              frameAck,
    output logic              overflow,
    output logic [7:0]        dropCount
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned DESC_AW = $clog2(DESC_DEPTH);
    localparam int unsigned CNT_W   = DESC_AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DROP   = 2'd3;

    logic                r_ss_meta;
    logic                r_ss_sync;
    logic                r_ss_act_q;
    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [LEN_W-1:0]    r_used;
    logic [ADDR_W-1:0]   r_frame_start;
    logic [LEN_W-1:0]    r_frame_len;
    logic [ADDR_W-1:0]   r_desc_start [DESC_DEPTH];
    logic [LEN_W-1:0]    r_desc_len   [DESC_DEPTH];
    logic [DESC_AW-1:0]  r_desc_wr;
    logic [DESC_AW-1:0]  r_desc_rd;
    logic [CNT_W-1:0]    r_desc_cnt;
    logic                r_overflow;
    logic [7:0]          r_drop_cnt;

    logic                w_ss_act;
    logic                w_ss_start;
    logic                w_ss_end;
    logic                w_buf_full;
    logic                w_desc_full;
    logic                w_ack;
    logic [1:0]          w_state_next;
    logic                w_write;
    logic                w_rewind;
    logic                w_push;
    logic                w_begin;
    logic [LEN_W-1:0]    w_ack_len;
    logic [LEN_W-1:0]    w_rew_len;

    // Slave-select edge decode (ss_act is the active-high form of SPI_SS)
    assign w_ss_act    = ~r_ss_sync;
    assign w_ss_start  = w_ss_act & ~r_ss_act_q;
    assign w_ss_end    = ~w_ss_act & r_ss_act_q;

    assign w_buf_full  = (r_used == LEN_W'(DEPTH));
    assign w_desc_full = (r_desc_cnt == CNT_W'(DESC_DEPTH));
    assign frameValid  = (r_desc_cnt != '0);
    assign frameStart  = r_desc_start[r_desc_rd];
    assign frameLen    = r_desc_len[r_desc_rd];
    assign w_ack       = frameAck & frameValid;
    assign w_ack_len   = w_ack ? frameLen : '0;
    assign w_rew_len   = w_rewind ? r_frame_len : '0;

    assign bufWE       = w_write;
    assign bufWrAddr   = r_wr_ptr;
    assign bufWrData   = rcMemData;
    assign overflow    = r_overflow;
    assign dropCount   = r_drop_cnt;

    // Two-flop synchroniser and edge-history register for SPI_SS
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ss_meta  <= 1'b1;
            r_ss_sync  <= 1'b1;
            r_ss_act_q <= 1'b0;
        end else begin
            r_ss_meta  <= SPI_SS;
            r_ss_sync  <= r_ss_meta;
            r_ss_act_q <= w_ss_act;
        end
    end

    // State register
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_rewind     = 1'b0;
        w_push       = 1'b0;
        w_begin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_start) begin
                    w_begin      = 1'b1;
                    w_state_next = S_RECV;
                end
            end
            S_RECV: begin
                if (rcMemWE && !w_buf_full) w_write = 1'b1;
                if (rcMemWE && w_buf_full) begin
                    // Frame ending on the very word that overflowed: drop now
                    if (w_ss_end) begin
                        w_rewind     = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DROP;
                    end
                end else if (w_ss_end) begin
                    if ((r_frame_len == '0) && !w_write) w_state_next = S_IDLE;
                    else                                 w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (!w_desc_full || w_ack) w_push   = 1'b1;
                else                       w_rewind = 1'b1;
                w_state_next = S_IDLE;
            end
            S_DROP: begin
                if (w_ss_end) begin
                    w_rewind     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Buffer pointers, occupancy, current-frame tracking and drop statistics
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_used        <= '0;
            r_frame_start <= '0;
            r_frame_len   <= '0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_used <= r_used + LEN_W'(w_write) - w_ack_len - w_rew_len;
            if (w_rewind)     r_wr_ptr <= r_frame_start;
            else if (w_write) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_ack) r_rd_ptr <= r_rd_ptr + frameLen[ADDR_W-1:0];
            if (w_begin) begin
                r_frame_start <= r_wr_ptr;
                r_frame_len   <= '0;
            end else if (w_write) begin
                r_frame_len   <= r_frame_len + LEN_W'(1);
            end
            if (w_rewind) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Descriptor FIFO: push on commit, pop on consumer ack
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DESC_DEPTH); i++) begin
                r_desc_start[i] <= '0;
                r_desc_len[i]   <= '0;
            end
            r_desc_wr  <= '0;
            r_desc_rd  <= '0;
            r_desc_cnt <= '0;
        end else begin
            if (w_push) begin
                r_desc_start[r_desc_wr] <= r_frame_start;
                r_desc_len[r_desc_wr]   <= r_frame_len;
                r_desc_wr               <= r_desc_wr + DESC_AW'(1);
            end
            if (w_ack) r_desc_rd <= r_desc_rd + DESC_AW'(1);
            r_desc_cnt <= r_desc_cnt + CNT_W'(w_push) - CNT_W'(w_ack);
        end
    end

    // Occupancy must always match the pointer distance (full aliases to 0)
    a_used_matches_ptrs: assert property (@(posedge SysClk) disable iff (!Reset_n)
        r_used[ADDR_W-1:0] == ADDR_W'(r_wr_ptr - r_rd_ptr));

endmodule

// File: tb/tb_spi_rc_frame_ctrl.sv
// Scoreboard bench for spi_rc_frame_ctrl: stimulus pushes expected BRAM writes
// and frame descriptors; a forked monitor compares them as the DUT presents them.
module tb_spi_rc_frame_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int DD    = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] s;
        logic [AW:0]   l;
    } desc_t;

    logic          SysClk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          SPI_SS = 1'b1;
    logic [15:0]   rcMemData = '0;
    logic          rcMemWE = 1'b0;
    logic [AW-1:0] bufWrAddr;
    logic [15:0]   bufWrData;
    logic          bufWE;
    logic          frameValid;
    logic [AW-1:0] frameStart;
    logic [AW:0]   frameLen;
    logic          frameAck = 1'b0;
    logic          overflow;
    logic [7:0]    dropCount;

    int n_checks = 0;
    int n_err    = 0;
    wr_t   wq[$];
    desc_t dq[$];

    spi_rc_frame_ctrl #(.ADDR_W(AW), .DESC_DEPTH(DD)) dut (
        .SysClk(SysClk), .Reset_n(Reset_n), .SPI_SS(SPI_SS),
        .rcMemData(rcMemData), .rcMemWE(rcMemWE),
        .bufWrAddr(bufWrAddr), .bufWrData(bufWrData), .bufWE(bufWE),
        .frameValid(frameValid), .frameStart(frameStart), .frameLen(frameLen),
        .frameAck(frameAck), .overflow(overflow), .dropCount(dropCount)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic exp_desc(input int s, input int l);
        dq.push_back(desc_t'{s: AW'(s), l: (AW+1)'(l)});
    endtask

    // One SS-delimited frame of n words; the first n_wr are expected in the BRAM
    task automatic frame(input int n, input logic [15:0] base, input int wr_start,
                         input int n_wr, input bit ack_commit);
        SPI_SS = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < n; i++) begin
            if (i < n_wr)
                wq.push_back(wr_t'{a: AW'((wr_start + i) % DEPTH), d: base + 16'(i)});
            rcMemData = base + 16'(i);
            rcMemWE   = 1'b1;
            tick();
            rcMemWE   = 1'b0;
        end
        SPI_SS = 1'b1;
        repeat (3) tick();
        if (ack_commit) frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
        repeat (2) tick();
    endtask

    task automatic ack();
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
    endtask

    task automatic do_reset();
        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_descs", 64'(dq.size()), 64'd0);
        wq.delete();
        dq.delete();
        Reset_n = 1'b0;
        SPI_SS  = 1'b1;
        rcMemWE = 1'b0;
        frameAck = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge SysClk);
                if (Reset_n) begin
                    if (bufWE) begin
                        if (wq.size() == 0) begin
                            chk("unexpected_write", 64'(bufWrAddr), 64'hFFFF);
                        end else begin
                            wr_t w;
                            w = wq.pop_front();
                            chk("wr_addr", 64'(bufWrAddr), 64'(w.a));
                            chk("wr_data", 64'(bufWrData), 64'(w.d));
                        end
                    end
                    if (frameAck && frameValid) begin
                        if (dq.size() == 0) begin
                            chk("unexpected_desc", 64'({frameStart, frameLen}), 64'hFFFF);
                        end else begin
                            desc_t e;
                            e = dq.pop_front();
                            chk("desc_start", 64'(frameStart), 64'(e.s));
                            chk("desc_len", 64'(frameLen), 64'(e.l));
                        end
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_frameValid", 64'(frameValid), 64'd0);
        chk("rst_bufWE", 64'(bufWE), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_dropCount", 64'(dropCount), 64'd0);
        Reset_n = 1'b1;
        repeat (2) tick();
        chk("rst_used", 64'(dut.r_used), 64'd0);

        // Single frame; stray strobe in IDLE must not write
        rcMemWE = 1'b1;
        #1;
        chk("idle_we_ignored", 64'(bufWE), 64'd0);
        tick();
        rcMemWE = 1'b0;
        frame(4, 16'h1111, 0, 4, 0);
        chk("t1_valid", 64'(frameValid), 64'd1);
        chk("t1_start", 64'(frameStart), 64'd0);
        chk("t1_len", 64'(frameLen), 64'd4);
        exp_desc(0, 4);
        ack();
        chk("t1_valid_after_ack", 64'(frameValid), 64'd0);
        chk("t1_used", 64'(dut.r_used), 64'd0);

        // Two frames queued, then acked
        do_reset();
        frame(3, 16'h2000, 0, 3, 0);
        frame(5, 16'h3000, 3, 5, 0);
        exp_desc(0, 3);
        exp_desc(3, 5);
        ack();
        ack();
        chk("t2_rd_ptr", 64'(dut.r_rd_ptr), 64'd8);
        chk("t2_valid", 64'(frameValid), 64'd0);

        // Buffer overflow: DEPTH-2 words pending, next 4-word frame dropped
        do_reset();
        frame(DEPTH - 2, 16'h4000, 0, DEPTH - 2, 0);
        frame(4, 16'h5000, DEPTH - 2, 2, 0);
        chk("t3_wr_ptr", 64'(dut.r_wr_ptr), 64'(DEPTH - 2));
        chk("t3_used", 64'(dut.r_used), 64'(DEPTH - 2));
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_dropCount", 64'(dropCount), 64'd1);
        chk("t3_desc_count", 64'(dut.r_desc_cnt), 64'd1);
        exp_desc(0, DEPTH - 2);
        ack();

        // Reset in the middle of a frame clears everything asynchronously
        SPI_SS = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            wq.push_back(wr_t'{a: AW'((DEPTH - 2 + i) % DEPTH), d: 16'h6000 + 16'(i)});
            rcMemData = 16'h6000 + 16'(i);
            rcMemWE   = 1'b1;
            tick();
            rcMemWE   = 1'b0;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_dropCount", 64'(dropCount), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);
        chk("t6_wr_ptr", 64'(dut.r_wr_ptr), 64'd0);
        chk("t6_used", 64'(dut.r_used), 64'd0);
        chk("t6_bufWrAddr", 64'(bufWrAddr), 64'd0);
        SPI_SS = 1'b1;
        tick();
        Reset_n = 1'b1;
        repeat (2) tick();
        frame(3, 16'h7000, 0, 3, 0);
        chk("t6_len", 64'(frameLen), 64'd3);
        exp_desc(0, 3);
        ack();

        // Descriptor queue full: ninth frame dropped
        do_reset();
        for (int f = 0; f < DD; f++) frame(1, 16'h8000 + 16'(f), f, 1, 0);
        frame(1, 16'h8100, DD, 1, 0);
        chk("t4_dropCount", 64'(dropCount), 64'd1);
        chk("t4_wr_ptr", 64'(dut.r_wr_ptr), 64'(DD));
        chk("t4_used", 64'(dut.r_used), 64'(DD));
        for (int f = 0; f < DD; f++) exp_desc(f, 1);
        repeat (DD) ack();

        // Descriptor queue full but acked in the commit cycle: accepted
        do_reset();
        for (int f = 0; f < DD; f++) frame(1, 16'h9000 + 16'(f), f, 1, 0);
        for (int f = 0; f <= DD; f++) exp_desc(f, 1);
        frame(1, 16'h9100, DD, 1, 1);
        chk("t4b_dropCount", 64'(dropCount), 64'd0);
        chk("t4b_overflow", 64'(overflow), 64'd0);
        repeat (DD) ack();
        chk("t4b_valid", 64'(frameValid), 64'd0);

        // Zero-length frame, then a frame wrapping the buffer end
        do_reset();
        frame(0, 16'h0, 0, 0, 0);
        chk("t5_zero_valid", 64'(frameValid), 64'd0);
        chk("t5_zero_wr_ptr", 64'(dut.r_wr_ptr), 64'd0);
        frame(DEPTH - 2, 16'hA000, 0, DEPTH - 2, 0);
        exp_desc(0, DEPTH - 2);
        ack();
        frame(4, 16'hB000, DEPTH - 2, 4, 0);
        chk("t5_wrap_start", 64'(frameStart), 64'(DEPTH - 2));
        chk("t5_wrap_len", 64'(frameLen), 64'd4);
        exp_desc(DEPTH - 2, 4);
        ack();
        chk("t5_used", 64'(dut.r_used), 64'd0);

        // Full-buffer frame of exactly DEPTH words is legal
        do_reset();
        frame(DEPTH, 16'hC000, 0, DEPTH, 0);
        chk("t7_len", 64'(frameLen), 64'(DEPTH));
        chk("t7_dropCount", 64'(dropCount), 64'd0);
        exp_desc(0, DEPTH);
        ack();

        repeat (2) tick();
        chk("end_pending_writes", 64'(wq.size()), 64'd0);
        chk("end_pending_descs", 64'(dq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
